// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register-file write port between two writers
//                (A: core writeback, B: debug/loader) using round-robin
//                valid/ready arbitration, plus a clear sequencer that
//                zeroes registers 1..2**AW-1. All rf_* outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_CLEAR = 1'b1;

  // Counter value after the last address (2**AW-1) has been issued. The
  // extra MSB keeps this compare free of wrap-around.
  localparam logic [AW:0] c_CNT_END = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] c_CNT_TWO = (AW+1)'(2);

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic          r_prio_b;   // 1: B wins the next tie, 0: A wins
  logic [AW:0]   r_cnt;      // next address to be issued during a clear
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_clr_start;
  logic          w_clr_last;

  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_busy;
  logic          r_done;

  assign w_clr_start = (r_state == c_IDLE) && clr_req;
  assign w_clr_last  = (r_state == c_CLEAR) && (r_cnt == c_CNT_END);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: enter CLEAR on a sampled request, leave once every address is issued.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (clr_req)    w_next_state = c_CLEAR;
      c_CLEAR: if (w_clr_last) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Grant decode: a pending clear request takes the port ahead of both writers.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if ((r_state == c_IDLE) && !clr_req) begin
      if (a_valid && b_valid) begin
        w_gnt_a = !r_prio_b;
        w_gnt_b = r_prio_b;
      end else begin
        w_gnt_a = a_valid;
        w_gnt_b = b_valid;
      end
    end
  end

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;

  // Round-robin pointer: only moves when somebody is actually granted.
  always_ff @(posedge clk) begin
    if (rst)          r_prio_b <= 1'b0;
    else if (w_gnt_a) r_prio_b <= 1'b1;
    else if (w_gnt_b) r_prio_b <= 1'b0;
  end

  // Registered write port, clear counter and clear status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (w_clr_start) begin
        // The first zero write (address 1) is issued on the entry edge so
        // address k appears k cycles after the request was sampled.
        r_we    <= 1'b1;
        r_waddr <= AW'(1);
        r_wdata <= '0;
        r_busy  <= 1'b1;
        r_cnt   <= c_CNT_TWO;
      end else if (w_clr_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_cnt  <= '0;
      end else if (r_state == c_CLEAR) begin
        r_we    <= 1'b1;
        r_waddr <= r_cnt[AW-1:0];
        r_wdata <= '0;
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_gnt_a) begin
        // Writes to register 0 are acknowledged but never committed.
        r_we    <= (a_addr != '0);
        r_waddr <= a_addr;
        r_wdata <= a_data;
      end else if (w_gnt_b) begin
        r_we    <= (b_addr != '0);
        r_waddr <= b_addr;
        r_wdata <= b_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign clr_busy = r_busy;
  assign clr_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, clr_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, clr_busy, clr_done, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; b_valid = 0; clr_req = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_ardy", a_ready, 0);

    // Single A write.
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1;
    check("a1_ready", a_ready, 1);
    check("a1_bready", b_ready, 0);
    tick();
    a_valid = 0;
    check("a1_we", rf_we, 1);
    check("a1_waddr", rf_waddr, 5);
    check("a1_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("a1_we_off", rf_we, 0);
    check("a1_waddr_hold", rf_waddr, 5);

    // B write to register 0: acknowledged, dropped. Also hands priority back to A.
    b_valid = 1; b_addr = 0; b_data = 32'h1234;
    #1;
    check("b0_ready", b_ready, 1);
    tick();
    b_valid = 0;
    check("b0_we", rf_we, 0);
    check("b0_waddr", rf_waddr, 0);
    check("b0_wdata", rf_wdata, 32'h1234);

    // Continuous tie: A,B,A,B.
    a_valid = 1; a_addr = 3; a_data = 32'hA0A0;
    b_valid = 1; b_addr = 7; b_data = 32'hB0B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tie_ardy", a_ready, (i % 2 == 0));
      check("tie_brdy", b_ready, (i % 2 == 1));
      tick();
      check("tie_we", rf_we, 1);
      check("tie_waddr", rf_waddr, (i % 2 == 0) ? 3 : 7);
      check("tie_wdata", rf_wdata, (i % 2 == 0) ? 32'hA0A0 : 32'hB0B0);
    end
    a_valid = 0; b_valid = 0;
    tick();

    // Clear request colliding with an A request.
    clr_req = 1; a_valid = 1; a_addr = 9; a_data = 32'h99;
    #1;
    check("clr_ardy_n", a_ready, 0);
    tick();
    clr_req = 0;
    for (int k = 1; k <= 31; k++) begin
      check("clr_we", rf_we, 1);
      check("clr_waddr", rf_waddr, k);
      check("clr_wdata", rf_wdata, 0);
      check("clr_busy", clr_busy, 1);
      check("clr_done_n", clr_done, 0);
      check("clr_ardy", a_ready, 0);
      tick();
    end
    check("clr_end_done", clr_done, 1);
    check("clr_end_busy", clr_busy, 0);
    check("clr_end_we", rf_we, 0);
    check("clr_end_ardy", a_ready, 1);
    tick();
    a_valid = 0;
    check("clr_a_we", rf_we, 1);
    check("clr_a_waddr", rf_waddr, 9);
    check("clr_a_done", clr_done, 0);

    // Clear aborted by reset at step 10 (A was granted last, so B holds priority now).
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 1; k < 10; k++) tick();
    check("abort_step10", rf_waddr, 10);
    rst = 1;
    tick();
    rst = 0;
    check("abort_we", rf_we, 0);
    check("abort_busy", clr_busy, 0);
    check("abort_done", clr_done, 0);
    check("abort_waddr", rf_waddr, 0);
    for (int k = 0; k < 25; k++) begin
      tick();
      check("abort_no_done", clr_done, 0);
    end
    a_valid = 1; a_addr = 4; a_data = 32'h44;
    b_valid = 1; b_addr = 6; b_data = 32'h66;
    #1;
    check("abort_tie_a", a_ready, 1);
    check("abort_tie_b", b_ready, 0);
    tick();
    a_valid = 0; b_valid = 0;
    check("abort_tie_waddr", rf_waddr, 4);

    // Alternating singles then a tie: B granted last, so A wins.
    a_valid = 1; a_addr = 11; a_data = 32'h11;
    #1;
    check("alt_a", a_ready, 1);
    tick();
    a_valid = 0;
    b_valid = 1; b_addr = 12; b_data = 32'h12;
    #1;
    check("alt_b", b_ready, 1);
    check("alt_b_na", a_ready, 0);
    tick();
    check("alt_b_waddr", rf_waddr, 12);
    a_valid = 1; a_addr = 13; a_data = 32'h13;
    b_addr = 14; b_data = 32'h14;
    #1;
    check("alt_tie_a", a_ready, 1);
    check("alt_tie_b", b_ready, 0);
    tick();
    a_valid = 0; b_valid = 0;
    check("alt_tie_waddr", rf_waddr, 13);
    check("alt_tie_wdata", rf_wdata, 32'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
